// File: rtl/uart_rx_if.sv
// Receive-side bundle between the serial pin, the 8N1 deframer and the byte consumer.
// The deframer takes the master view; the line driver / consumer takes the slave view.
interface uart_rx_if;
    logic       rx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       frame_err;
    logic       busy;

    modport master (
        input  rx,
        output rx_ready,
        output rx_data,
        output frame_err,
        output busy
    );

    modport slave (
        output rx,
        input  rx_ready,
        input  rx_data,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/uart_rx.sv
// Oversampling 8N1 receiver: two-flop synchronizer on the pin, then a deframing FSM
// that emits a one-cycle rx_ready per good byte or frame_err per bad stop bit.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.master bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_CNT = CW'(HALF_BIT - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BREAK = 3'd4;

    logic          r_s1;
    logic          r_rx_s;
    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bidx;
    logic [7:0]    r_sh;
    logic [7:0]    r_data;
    logic          r_ready;
    logic          r_ferr;

    logic w_bit_end;
    logic w_half;

    assign w_bit_end = (r_cnt == LAST_CNT);
    assign w_half    = (r_cnt == HALF_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= 1'b1;
            r_rx_s  <= 1'b1;
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bidx  <= '0;
            r_sh    <= '0;
            r_data  <= '0;
            r_ready <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_s1    <= bus.rx;
            r_rx_s  <= r_s1;
            r_ready <= 1'b0;
            r_ferr  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!r_rx_s) begin
                        r_state <= START;
                        r_cnt   <= '0;
                    end
                end
                START: begin
                    // Re-check the line mid start bit so short glitches are dropped.
                    if (w_half) begin
                        if (!r_rx_s) begin
                            r_state <= DATA;
                            r_cnt   <= '0;
                            r_bidx  <= '0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_sh  <= {r_rx_s, r_sh[7:1]};
                        r_cnt <= '0;
                        if (r_bidx == 3'd7) r_state <= STOP;
                        else                r_bidx  <= r_bidx + 3'd1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_rx_s) begin
                            r_data  <= r_sh;
                            r_ready <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                BREAK: begin
                    // Wait out a held-low line so it yields one frame_err only.
                    if (r_rx_s) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.rx_ready  = r_ready;
    assign bus.rx_data   = r_data;
    assign bus.frame_err = r_ferr;
    assign bus.busy      = (r_state != IDLE);
endmodule
